// File: rtl/ps2_key_filter_if.sv
// ps2_key_filter_if: byte-strobe input and key-report output bundle for the PS/2 key filter
interface ps2_key_filter_if;
    logic       ready;
    logic [7:0] datain;
    logic       valido;
    logic       key_break;
    logic [3:0] key_idx;
    logic       key_ext;

    modport master (
        output ready, datain,
        input  valido, key_break, key_idx, key_ext
    );

    modport slave (
        input  ready, datain,
        output valido, key_break, key_idx, key_ext
    );
endinterface

// File: rtl/ps2_key_filter.sv
// ps2_key_filter: decodes PS/2 scancode bytes into make/break reports for a small key table
module ps2_key_filter #(
    parameter int NUM_KEYS        = 9,
    parameter int TIMEOUT_CYC     = 50000,
    parameter int SUPPRESS_REPEAT = 1,
    parameter int ACCEPT_EXT      = 1
) (
    input logic             clk,
    input logic             reset,
    ps2_key_filter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BRK     = 2'd1;
    localparam logic [1:0] EXT     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam int N_ACT = (NUM_KEYS < 9) ? NUM_KEYS : 9;
    localparam int HW    = 2 * NUM_KEYS;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] PFX_EXT = 8'hE0;

    function automatic logic [7:0] key_code(input int i);
        case (i)
            0:       key_code = 8'h16;
            1:       key_code = 8'h1E;
            2:       key_code = 8'h26;
            3:       key_code = 8'h4D;
            4:       key_code = 8'h21;
            5:       key_code = 8'h32;
            6:       key_code = 8'h31;
            7:       key_code = 8'h5A;
            default: key_code = 8'h15;
        endcase
    endfunction

    logic [1:0]    r_state;
    logic [TW-1:0] r_tmr;
    logic [HW-1:0] r_held;
    logic          r_valid;
    logic          r_brk;
    logic [3:0]    r_idx;
    logic          r_ext;

    logic          w_hit;
    logic [3:0]    w_idx;
    logic          w_is_ext;
    logic          w_is_brk;
    logic [4:0]    w_bit;
    logic [HW-1:0] w_mask;
    logic          w_held;
    logic          w_rep_ok;
    logic          w_tmo;
    logic          w_make;
    logic          w_break;
    logic [1:0]    w_next;

    // Match the incoming byte against the active part of the key table
    always_comb begin
        w_hit = 1'b0;
        w_idx = 4'd0;
        for (int i = 0; i < N_ACT; i++) begin
            if (bus.datain == key_code(i)) begin
                w_hit = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    // Report qualification and next-state selection; a byte always wins over the timeout
    always_comb begin
        w_is_ext = (r_state == EXT) || (r_state == EXT_BRK);
        w_is_brk = (r_state == BRK) || (r_state == EXT_BRK);
        w_bit    = w_is_ext ? {1'b0, w_idx} + 5'(NUM_KEYS) : {1'b0, w_idx};
        w_mask   = HW'(1) << w_bit;
        w_held   = |(r_held & w_mask);
        w_rep_ok = bus.ready && w_hit && ((ACCEPT_EXT != 0) || !w_is_ext);
        w_make   = w_rep_ok && !w_is_brk && !((SUPPRESS_REPEAT != 0) && w_held);
        w_break  = w_rep_ok && w_is_brk;
        w_tmo    = !bus.ready && (r_state != IDLE) && (r_tmr == TW'(TIMEOUT_CYC - 1));
        w_next   = bus.ready ? ((bus.datain == PFX_BRK) ? (w_is_ext ? EXT_BRK : BRK) :
                                (bus.datain == PFX_EXT) ? EXT : IDLE) :
                   w_tmo ? IDLE : r_state;
    end

    // Sequence state, inter-byte timer, held-key vector and registered reports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_held  <= '0;
            r_valid <= 1'b0;
            r_brk   <= 1'b0;
            r_idx   <= 4'd0;
            r_ext   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmr   <= (bus.ready || (r_state == IDLE) || w_tmo) ? '0 : r_tmr + TW'(1);
            r_valid <= w_make;
            r_brk   <= w_break;
            if (w_make || w_break) begin
                r_idx <= w_idx;
                r_ext <= w_is_ext;
            end
            if (w_make)
                r_held <= r_held | w_mask;
            else if (w_break)
                r_held <= r_held & ~w_mask;
        end
    end

    assign bus.valido    = r_valid;
    assign bus.key_break = r_brk;
    assign bus.key_idx   = r_idx;
    assign bus.key_ext   = r_ext;
endmodule

// File: tb/tb_ps2_key_filter.sv
// tb_ps2_key_filter: four filter configurations fed one byte stream, checked against a scancode model
module tb_ps2_key_filter;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [7:0] datain;

    always #5 clk = ~clk;

    ps2_key_filter_if bus0();
    ps2_key_filter_if bus1();
    ps2_key_filter_if bus2();
    ps2_key_filter_if bus3();

    assign bus0.ready = ready;  assign bus0.datain = datain;
    assign bus1.ready = ready;  assign bus1.datain = datain;
    assign bus2.ready = ready;  assign bus2.datain = datain;
    assign bus3.ready = ready;  assign bus3.datain = datain;

    ps2_key_filter #(.NUM_KEYS(9), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(1), .ACCEPT_EXT(1))
        u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    ps2_key_filter #(.NUM_KEYS(9), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(0), .ACCEPT_EXT(1))
        u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    ps2_key_filter #(.NUM_KEYS(9), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(1), .ACCEPT_EXT(0))
        u2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    ps2_key_filter #(.NUM_KEYS(3), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(1), .ACCEPT_EXT(1))
        u3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    logic [3:0] ov, ob, oe;
    logic [3:0] oi [4];
    assign ov = {bus3.valido, bus2.valido, bus1.valido, bus0.valido};
    assign ob = {bus3.key_break, bus2.key_break, bus1.key_break, bus0.key_break};
    assign oe = {bus3.key_ext, bus2.key_ext, bus1.key_ext, bus0.key_ext};
    assign oi[0] = bus0.key_idx;
    assign oi[1] = bus1.key_idx;
    assign oi[2] = bus2.key_idx;
    assign oi[3] = bus3.key_idx;

    int   nk [4] = '{9, 9, 9, 3};
    bit   sr [4] = '{1, 0, 1, 1};
    bit   ae [4] = '{1, 1, 0, 1};
    logic [7:0] tab [9] = '{8'h16, 8'h1E, 8'h26, 8'h4D, 8'h21, 8'h32, 8'h31, 8'h5A, 8'h15};

    int         st [4];
    logic [31:0] held [4];
    bit         ev [4], eb [4], ee [4];
    logic [3:0] ei [4];
    int         gap;
    int         pv [4], pb [4];
    int         errs = 0;
    int         checks = 0;

    function automatic int key_of(input logic [7:0] b, input int n);
        for (int i = 0; i < n && i < 9; i++)
            if (tab[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            st[k] = 0; held[k] = '0; ev[k] = 0; eb[k] = 0; ee[k] = 0; ei[k] = 4'd0;
        end
        gap = 0;
    endtask

    task automatic model(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            int s;
            s = st[k];
            ev[k] = 0;
            eb[k] = 0;
            if (s != 0 && gap >= TO) s = 0;
            if (b == 8'hF0) s = (s >= 2) ? 3 : 1;
            else if (b == 8'hE0) s = 2;
            else begin
                int i, hb;
                bit x, br;
                i  = key_of(b, nk[k]);
                x  = (s >= 2);
                br = (s == 1 || s == 3);
                if (i >= 0 && (ae[k] || !x)) begin
                    hb = i * 2 + int'(x);
                    if (br) begin
                        held[k][hb] = 1'b0; eb[k] = 1; ei[k] = 4'(i); ee[k] = x;
                    end else if (!(sr[k] && held[k][hb])) begin
                        held[k][hb] = 1'b1; ev[k] = 1; ei[k] = 4'(i); ee[k] = x;
                    end
                end
                s = 0;
            end
            st[k] = s;
        end
        gap = 0;
    endtask

    task automatic tally();
        for (int k = 0; k < 4; k++) begin
            pv[k] += int'(ov[k]);
            pb[k] += int'(ob[k]);
        end
    endtask

    task automatic put(input logic [7:0] b);
        ready  = 1'b1;
        datain = b;
        @(negedge clk);
        model(b);
        tally();
    endtask

    task automatic idle(input int n);
        ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            gap++;
            for (int k = 0; k < 4; k++) begin ev[k] = 0; eb[k] = 0; end
            tally();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ready  = 1'b1;
        datain = 8'h1E;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ov[k], ob[k], oi[k], oe[k]} !== 7'd0) begin
                errs++;
                $display("FAIL reset dut%0d: got v=%b b=%b i=%0d e=%b want all 0", k, ov[k], ob[k], oi[k], oe[k]);
            end
        end
        reset = 1'b0;
        ready = 1'b0;
        model_reset();
        idle(2);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ov[k], ob[k]} !== 2'b00) begin
                errs++;
                $display("FAIL reset_ready_ignored dut%0d: got v=%b b=%b want 0 0", k, ov[k], ob[k]);
            end
        end
    endtask

    task automatic test_make();
        put(8'h1E);
        checks++;
        if ({ov[0], ob[0], oi[0], oe[0]} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            errs++;
            $display("FAIL make_1E: got v=%b b=%b i=%0d e=%b want v=1 b=0 i=1 e=0", ov[0], ob[0], oi[0], oe[0]);
        end
        idle(1);
        checks++;
        if ({ov[0], ob[0], oi[0]} !== {1'b0, 1'b0, 4'd1}) begin
            errs++;
            $display("FAIL make_pulse_width: got v=%b b=%b i=%0d want v=0 b=0 i=1", ov[0], ob[0], oi[0]);
        end
        put(8'hF0); put(8'h1E); idle(1);
        for (int n = 0; n < 6; n++) begin
            put(tab[$urandom_range(0, 8)]);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({ov[k], ob[k], oi[k], oe[k]} !== {ev[k], eb[k], ei[k], ee[k]}) begin
                    errs++;
                    $display("FAIL make_rand dut%0d byte %h: got v=%b b=%b i=%0d e=%b want v=%b b=%b i=%0d e=%b",
                             k, datain, ov[k], ob[k], oi[k], oe[k], ev[k], eb[k], ei[k], ee[k]);
                end
            end
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_repeat();
        int v0, v1, b0;
        put(8'hF0); put(8'h1E); idle(1);
        v0 = pv[0]; v1 = pv[1];
        put(8'h1E); put(8'h1E); put(8'h1E); idle(1);
        checks++;
        if (pv[0] - v0 !== 1) begin
            errs++;
            $display("FAIL repeat_suppressed: got %0d valido pulses want 1", pv[0] - v0);
        end
        checks++;
        if (pv[1] - v1 !== 3) begin
            errs++;
            $display("FAIL repeat_passed: got %0d valido pulses want 3", pv[1] - v1);
        end
        b0 = pb[0];
        put(8'hF0); put(8'h1E);
        checks++;
        if ({ob[0], ov[0], oi[0], oe[0]} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
            errs++;
            $display("FAIL break_1E: got b=%b v=%b i=%0d e=%b want b=1 v=0 i=1 e=0", ob[0], ov[0], oi[0], oe[0]);
        end
        idle(1);
        checks++;
        if (pb[0] - b0 !== 1) begin
            errs++;
            $display("FAIL break_count: got %0d key_break pulses want 1", pb[0] - b0);
        end
        put(8'hF0); put(8'h1E);
        checks++;
        if (ob[0] !== 1'b1) begin
            errs++;
            $display("FAIL break_unheld: got key_break=%b want 1", ob[0]);
        end
        idle(1);
    endtask

    task automatic test_ext();
        int v2, b2;
        v2 = pv[2]; b2 = pb[2];
        put(8'hE0); put(8'h5A);
        checks++;
        if ({ov[0], ob[0], oi[0], oe[0]} !== {1'b1, 1'b0, 4'd7, 1'b1}) begin
            errs++;
            $display("FAIL ext_make: got v=%b b=%b i=%0d e=%b want v=1 b=0 i=7 e=1", ov[0], ob[0], oi[0], oe[0]);
        end
        idle(2);
        put(8'hE0); put(8'hF0); put(8'h5A);
        checks++;
        if ({ov[0], ob[0], oi[0], oe[0]} !== {1'b0, 1'b1, 4'd7, 1'b1}) begin
            errs++;
            $display("FAIL ext_break: got v=%b b=%b i=%0d e=%b want v=0 b=1 i=7 e=1", ov[0], ob[0], oi[0], oe[0]);
        end
        idle(1);
        checks++;
        if ((pv[2] - v2) + (pb[2] - b2) !== 0) begin
            errs++;
            $display("FAIL ext_disabled: got %0d pulses want 0", (pv[2] - v2) + (pb[2] - b2));
        end
    endtask

    task automatic test_timeout();
        put(8'hF0); idle(TO); put(8'h16);
        checks++;
        if ({ov[0], ob[0], oi[0]} !== {1'b1, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL timeout_expired: got v=%b b=%b i=%0d want v=1 b=0 i=0", ov[0], ob[0], oi[0]);
        end
        idle(1);
        put(8'hF0); idle(TO - 1); put(8'h16);
        checks++;
        if ({ov[0], ob[0], oi[0]} !== {1'b0, 1'b1, 4'd0}) begin
            errs++;
            $display("FAIL timeout_edge_byte_wins: got v=%b b=%b i=%0d want v=0 b=1 i=0", ov[0], ob[0], oi[0]);
        end
        idle(1);
    endtask

    task automatic test_unknown();
        int v3;
        v3 = pv[3];
        put(8'h99);
        checks++;
        if ({ov, ob} !== 8'd0) begin
            errs++;
            $display("FAIL unknown_99: got v=%b b=%b want 0000 0000", ov, ob);
        end
        put(8'h4D); idle(1);
        checks++;
        if (pv[3] - v3 !== 0) begin
            errs++;
            $display("FAIL inactive_4D: got %0d pulses want 0", pv[3] - v3);
        end
        put(8'h26);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ov[k], ob[k], oi[k], oe[k]} !== {ev[k], eb[k], ei[k], ee[k]}) begin
                errs++;
                $display("FAIL unknown_then_idle dut%0d: got v=%b b=%b i=%0d e=%b want v=%b b=%b i=%0d e=%b",
                         k, ov[k], ob[k], oi[k], oe[k], ev[k], eb[k], ei[k], ee[k]);
            end
        end
        put(8'hF0); put(8'h26); put(8'hF0); put(8'h4D); idle(1);
    endtask

    task automatic test_reset_mid();
        put(8'hF0);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ov, ob} !== 8'd0 || oi[0] !== 4'd0 || oe[0] !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: got v=%b b=%b i=%0d e=%b want all 0", ov, ob, oi[0], oe[0]);
        end
        ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        put(8'h26);
        checks++;
        if ({ov[0], ob[0], oi[0], oe[0]} !== {1'b1, 1'b0, 4'd2, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_seq: got v=%b b=%b i=%0d e=%b want v=1 b=0 i=2 e=0", ov[0], ob[0], oi[0], oe[0]);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pool [12];
        int gaps [6];
        for (int i = 0; i < 9; i++) pool[i] = tab[i];
        pool[9] = 8'hE0; pool[10] = 8'hF0; pool[11] = 8'h99;
        gaps = '{0, 1, 3, TO - 1, TO, TO + 1};
        for (int n = 0; n < 300; n++) begin
            put(($urandom_range(0, 2) == 0) ? pool[$urandom_range(9, 11)] : pool[$urandom_range(0, 11)]);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({ov[k], ob[k], oi[k], oe[k]} !== {ev[k], eb[k], ei[k], ee[k]}) begin
                    errs++;
                    $display("FAIL stream dut%0d step %0d byte %h: got v=%b b=%b i=%0d e=%b want v=%b b=%b i=%0d e=%b",
                             k, n, datain, ov[k], ob[k], oi[k], oe[k], ev[k], eb[k], ei[k], ee[k]);
                end
            end
            idle(($urandom_range(0, 1) == 0) ? 0 : gaps[$urandom_range(0, 5)]);
        end
        idle(1);
    endtask

    initial begin
        ready  = 1'b0;
        datain = 8'h00;
        reset  = 1'b1;
        for (int k = 0; k < 4; k++) begin pv[k] = 0; pb[k] = 0; end
        model_reset();
        test_reset();
        test_make();
        test_repeat();
        test_ext();
        test_timeout();
        test_unknown();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_filter.md
PS2_KEY_FILTER -- requirements
Module: ps2_key_filter

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 9, giving the number of accepted scancodes (1..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 50000, giving the clock cycles allowed between a prefix byte and its follower.
REQ-003 The block SHALL have parameter SUPPRESS_REPEAT, default 1; when 1, typematic repeats of a held key are dropped.
REQ-004 The block SHALL have parameter ACCEPT_EXT, default 1; when 0, all E0-prefixed sequences are discarded.
REQ-005 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port ready  input  1  byte strobe; each cycle ready=1 delivers one byte on datain.
REQ-008 Port datain  input  8  received PS/2 scancode byte.
REQ-009 Port valido  output  1  one-cycle pulse: accepted make code.
REQ-010 Port key_break  output  1  one-cycle pulse: accepted break code.
REQ-011 Port key_idx  output  4  table index of the reported key; held until the next report.
REQ-012 Port key_ext  output  1  reported key carried the E0 prefix; held with key_idx.

Function
REQ-013 Key table, index 0..8: 16,1E,26,4D,21,32,31,5A,15 (hex). Only indices < NUM_KEYS are active; a byte matching no active entry is unknown.
REQ-014 FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-015 IDLE: F0->BRK; E0->EXT; known code->make report, stay IDLE; unknown->no report, stay IDLE.
REQ-016 BRK: known code->break report, ->IDLE; unknown->no report, ->IDLE; F0->stay BRK; E0->EXT (malformed prefix is restarted).
REQ-017 EXT: F0->EXT_BRK; E0->stay EXT; known code->make report with key_ext=1, ->IDLE; unknown->IDLE.
REQ-018 EXT_BRK: known code->break report with key_ext=1, ->IDLE; unknown->IDLE; E0->EXT; F0->stay EXT_BRK.
REQ-019 When ACCEPT_EXT=0, reports from EXT/EXT_BRK SHALL be suppressed; state transitions are unchanged.
REQ-020 Latency: valido/key_break assert exactly one cycle after the ready cycle that carried the final byte, for exactly one cycle; key_idx/key_ext update in that same cycle.
REQ-021 Held vector: 2*NUM_KEYS bits, one per (index, ext). Make sets the bit; break clears it.
REQ-022 With SUPPRESS_REPEAT=1, a make for a key whose held bit is already set SHALL produce no pulse and leave key_idx/key_ext unchanged; with 0, every make pulses.
REQ-023 A break for a key whose held bit is clear SHALL still pulse key_break.
REQ-024 Timeout counter: cleared on every ready cycle and in IDLE; increments each cycle in a non-IDLE state without ready; at TIMEOUT_CYC-1 the FSM returns to IDLE with no report, counter cleared.
REQ-025 Timeout expiry coinciding with ready SHALL be ignored: the byte is processed in the current state.
REQ-026 valido and key_break SHALL never assert in the same cycle.
REQ-027 All outputs SHALL be driven from registers; no combinational path from ready/datain to outputs.

Reset
REQ-028 While reset=1: state=IDLE, timer=0, held vector=0, valido=0, key_break=0, key_idx=0, key_ext=0, asynchronously.
REQ-029 Reset asserted mid-sequence (e.g. after F0) SHALL abandon the sequence; the first byte after release is decoded from IDLE.
REQ-030 ready during reset SHALL be ignored.

Verification
REQ-031 Bytes 1E -> valido pulse one cycle later, key_idx=1, key_ext=0; key_break stays 0.
REQ-032 Bytes 1E,1E,1E (SUPPRESS_REPEAT=1) then F0,1E -> one valido pulse only, then one key_break pulse with key_idx=1; repeating with SUPPRESS_REPEAT=0 gives three valido pulses.
REQ-033 Bytes E0,5A then E0,F0,5A -> valido with key_idx=7, key_ext=1; then key_break with key_idx=7, key_ext=1; with ACCEPT_EXT=0 no pulses.
REQ-034 Byte F0, then idle TIMEOUT_CYC cycles, then 16 -> no break; valido pulse with key_idx=0 (state returned to IDLE).
REQ-035 Byte 99 (unknown), and 4D with NUM_KEYS=3 -> no pulses; state remains IDLE.
REQ-036 Byte F0, reset pulse, then 26 -> valido pulse with key_idx=2, no key_break; all outputs 0 during reset.
